// File: rtl/cfg_pkg.sv
// cfg_pkg: constants, defaults and FSM state type shared by the cfg_loader slice.
package cfg_pkg;
    localparam logic [7:0] SYNC      = 8'hA5;
    localparam logic [7:0] CRC_POLY  = 8'h07;
    localparam int         CFG_W_DEF = 5;
    typedef enum logic [1:0] {ST_HUNT, ST_PAYLOAD, ST_CHECK, ST_COMMIT} state_t;
endpackage

// File: rtl/cfg_crc8.sv
// cfg_crc8: serial MSB-first CRC-8 over one bit per enabled cycle, with synchronous clear.
module cfg_crc8 import cfg_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_din,
    output logic [7:0] o_crc
);
    logic [7:0] r_crc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_crc <= '0;
        else if (i_clr)
            r_crc <= '0;
        else if (i_en)
            r_crc <= {r_crc[6:0], 1'b0} ^ ((r_crc[7] ^ i_din) ? CRC_POLY : 8'h00);
    end
    assign o_crc = r_crc;
endmodule

// File: rtl/cfg_loader.sv
// cfg_loader: hunts for SYNC in a serial bitstream, shadows one payload frame and commits it atomically.
// Define CFG_LOADER_CRC_EN to require and verify a CRC-8 trailer after the payload.
module cfg_loader import cfg_pkg::*; #(
    parameter int N_BLOCKS = 4,
    parameter int CFG_W    = CFG_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bs_valid,
    input  logic                      bs_data,
    output logic                      bs_ready,
    output logic [N_BLOCKS*CFG_W-1:0] cfg_out,
    output logic                      cfg_loaded,
    output logic                      done,
    output logic                      err
);
    localparam int P  = N_BLOCKS * CFG_W;
    localparam int CW = $clog2(((P > 8) ? P : 8) + 1);

    state_t          r_state, w_next;
    logic [7:0]      r_win;
    logic [P-1:0]    r_shadow, r_cfg;
    logic [CW-1:0]   r_cnt;
    logic            r_loaded, r_done, r_err;
    logic            w_acc, w_fail, w_crc_ok;
    logic [7:0]      w_win;
    state_t          w_pl_next;

    assign bs_ready = r_state != ST_COMMIT;
    assign w_acc    = bs_valid & bs_ready;
    assign w_win    = {r_win[6:0], bs_data};

`ifdef CFG_LOADER_CRC_EN
    logic [7:0] w_crc;
    cfg_crc8 u_crc (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state == ST_HUNT),
        .i_en  (w_acc && r_state == ST_PAYLOAD),
        .i_din (bs_data),
        .o_crc (w_crc)
    );
    // the window doubles as the trailer shift register while in CHECK
    assign w_crc_ok  = w_win == w_crc;
    assign w_pl_next = ST_CHECK;
`else
    assign w_crc_ok  = 1'b1;
    assign w_pl_next = ST_COMMIT;
`endif

    always_comb begin
        w_next = r_state;
        w_fail = 1'b0;
        case (r_state)
            ST_HUNT:    if (w_acc && w_win == SYNC) w_next = ST_PAYLOAD;
            ST_PAYLOAD: if (w_acc && r_cnt == CW'(P - 1)) w_next = w_pl_next;
            ST_CHECK: begin
                if (w_acc && r_cnt == CW'(7)) begin
                    w_next = w_crc_ok ? ST_COMMIT : ST_HUNT;
                    w_fail = !w_crc_ok;
                end
            end
            default:    w_next = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_HUNT;
            r_win    <= '0;
            r_shadow <= '0;
            r_cnt    <= '0;
            r_cfg    <= '0;
            r_loaded <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= r_state == ST_COMMIT;
            r_err   <= w_fail;
            if (w_next == ST_HUNT && r_state != ST_HUNT)
                r_win <= '0;
            else if (w_acc)
                r_win <= w_win;
            if (w_acc && r_state == ST_PAYLOAD)
                r_shadow <= {r_shadow[P-2:0], bs_data};
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_acc && r_state != ST_HUNT)
                r_cnt <= r_cnt + CW'(1);
            if (r_state == ST_COMMIT) begin
                r_cfg    <= r_shadow;
                r_loaded <= 1'b1;
            end
        end
    end

    assign cfg_out    = r_cfg;
    assign cfg_loaded = r_loaded;
    assign done       = r_done;
    assign err        = r_err;
endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: directed self-checking bench for cfg_loader with N_BLOCKS=2, CFG_W=5 (P=10).
module tb_cfg_loader;
    localparam int P = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         bs_valid = 1'b0;
    logic         bs_data = 1'b0;
    logic         bs_ready, cfg_loaded, done, err;
    logic [P-1:0] cfg_out;

    int  n_eval = 0;
    int  n_fail = 0;
    int  done_cnt = 0;
    int  err_cnt = 0;
    int  nready_cnt = 0;
    bit  stall = 1'b0;
    int  d0, e0, r0;

    cfg_loader #(.N_BLOCKS(2), .CFG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .bs_valid   (bs_valid),
        .bs_data    (bs_data),
        .bs_ready   (bs_ready),
        .cfg_out    (cfg_out),
        .cfg_loaded (cfg_loaded),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)      done_cnt   <= done_cnt + 1;
        if (err)       err_cnt    <= err_cnt + 1;
        if (!bs_ready) nready_cnt <= nready_cnt + 1;
    end

    initial begin
        #200000;
        $error("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_eval++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        bs_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        int k;
        if (stall) idle($urandom_range(0, 7));
        bs_valid = 1'b1;
        bs_data  = b;
        k = 0;
        while (!bs_ready && k < 16) begin
            @(negedge clk);
            k++;
        end
        if (k == 16) chk("ready_timeout", {31'b0, bs_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_payload(input logic [P-1:0] pl);
        for (int i = P - 1; i >= 0; i--) send_bit(pl[i]);
    endtask

    function automatic logic [7:0] crc8(input logic [P-1:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = P - 1; i >= 0; i--)
            c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
        return c;
    endfunction

    task automatic send_frame(input logic [P-1:0] pl);
        send_byte(8'hA5);
        send_payload(pl);
`ifdef CFG_LOADER_CRC_EN
        send_byte(crc8(pl));
`endif
    endtask

    // called right after the last frame bit was accepted: COMMIT is the current cycle
    task automatic finish_frame(input string tag, input logic [P-1:0] prev, input logic [P-1:0] exp);
        chk({tag, "_hold"}, {22'b0, cfg_out}, {22'b0, prev});
        chk({tag, "_ready_low"}, {31'b0, bs_ready}, 32'd0);
        idle(1);
        chk(tag, {22'b0, cfg_out}, {22'b0, exp});
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_loaded"}, {31'b0, cfg_loaded}, 32'd1);
        chk({tag, "_ready"}, {31'b0, bs_ready}, 32'd1);
        idle(3);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_cfg", {22'b0, cfg_out}, 32'd0);
        chk("rst_loaded", {31'b0, cfg_loaded}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'b0, bs_ready}, 32'd1);

        // basic load
        d0 = done_cnt;
        send_frame(10'b1011001101);
        finish_frame("basic", 10'h000, 10'h2CD);
        chk("basic_blk0", {27'b0, cfg_out[4:0]}, 32'b01101);
        chk("basic_blk1", {27'b0, cfg_out[9:5]}, 32'b10110);
        chk("basic_done_once", done_cnt - d0, 32'd1);

`ifdef CFG_LOADER_CRC_EN
        // corrupted trailer must be rejected without touching cfg_out
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hA5);
        send_payload(10'h155);
        send_byte(crc8(10'h155) ^ 8'h01);
        chk("crc_err_pulse", {31'b0, err}, 32'd1);
        idle(4);
        chk("crc_err_once", err_cnt - e0, 32'd1);
        chk("crc_no_done", done_cnt - d0, 32'd0);
        chk("crc_cfg_kept", {22'b0, cfg_out}, 32'h2CD);
        chk("crc_loaded_kept", {31'b0, cfg_loaded}, 32'd1);
`endif

        // 0x52 followed by the leading 1 of 0xA5 already forms a sync, so the first
        // "frame" starts early; a clean 0xFF-prefixed frame afterwards must still lock
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hFF);
        send_byte(8'h52);
        send_frame(10'h3FF);
        idle(4);
        chk("hunt_early_outcome", (done_cnt - d0) + (err_cnt - e0), 32'd1);
`ifndef CFG_LOADER_CRC_EN
        chk("hunt_early_cfg", {22'b0, cfg_out}, 32'h12F);
`endif
        send_byte(8'hFF);
        send_frame(10'h3FF);
        idle(4);
        chk("hunt_cfg", {22'b0, cfg_out}, 32'h3FF);

        // random stalls on every bit, sync and trailer included
        stall = 1'b1;
        d0 = done_cnt;
        send_frame(10'h2CD);
        stall = 1'b0;
        finish_frame("stall", 10'h3FF, 10'h2CD);
        chk("stall_done_once", done_cnt - d0, 32'd1);

        // reset in the middle of a payload
        send_byte(8'hA5);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        bs_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cfg", {22'b0, cfg_out}, 32'd0);
        chk("midrst_loaded", {31'b0, cfg_loaded}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {31'b0, bs_ready}, 32'd1);
        send_frame(10'h155);
        finish_frame("midrst_reload", 10'h000, 10'h155);

        // back-to-back frames with no idle between them
        d0 = done_cnt;
        r0 = nready_cnt;
        send_frame(10'h001);
        send_frame(10'h200);
        idle(4);
        chk("b2b_done_twice", done_cnt - d0, 32'd2);
        chk("b2b_ready_low", nready_cnt - r0, 32'd2);
        chk("b2b_cfg", {22'b0, cfg_out}, 32'h200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end
endmodule
